// File: rtl/multicycle_control.sv
// multicycle_control: FSM that sequences each RV32 instruction through
// FETCH, DECODE, EXEC, MEM and WB for a shared-memory multi-cycle datapath.
// Memory accesses wait on mem_ready_i, with a bounded timeout into a sticky ERR.
// Optional: define MULTICYCLE_ILLEGAL_TRAP_EN to send unrecognised opcodes
// to ERR. Without it they are retired as bubbles.
module multicycle_control #(
  parameter int OP_W        = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic               No_op_i,
  input  logic               mem_ready_i,
  input  logic               branch_taken_i,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               RegWrite_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemToReg_o,
  output logic               Branch_o,
  output logic               PCWrite_o,
  output logic               IRWrite_o,
  output logic               IorD_o,
  output logic [2:0]         state_o,
  output logic               err_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OP_W-1:0] OPC_R      = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OPC_I      = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OPC_LOAD   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OPC_STORE  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OPC_BRANCH = OP_W'(7'b1100011);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ALUOP_W-1:0] alu_op_dec;
  logic               alu_src_dec;
  logic               is_load_q, is_store_q;
  logic               op_in_legal;
  logic               cnt_hit;
  state_e             end_state;

  assign is_load_q   = (op_q == OPC_LOAD);
  assign is_store_q  = (op_q == OPC_STORE);
  assign op_in_legal = (Op_i == OPC_R) || (Op_i == OPC_I) || (Op_i == OPC_LOAD) ||
                       (Op_i == OPC_STORE) || (Op_i == OPC_BRANCH);
  assign cnt_hit     = (cnt_q == CNT_W'(MEM_TIMEOUT));
  // At the end of an instruction start_i decides whether to keep running.
  assign end_state   = start_i ? ST_FETCH : ST_IDLE;
  assign state_o     = state_q;

  // State, captured opcode and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU control decoded from the captured opcode; held through MEM and WB.
  always_comb begin
    alu_op_dec  = '0;
    alu_src_dec = 1'b0;
    case (op_q)
      OPC_I, OPC_LOAD: begin alu_op_dec = ALUOP_W'(2'b01); alu_src_dec = 1'b1; end
      OPC_STORE:       begin alu_op_dec = ALUOP_W'(2'b10); alu_src_dec = 1'b1; end
      OPC_BRANCH:      begin alu_op_dec = ALUOP_W'(2'b11); alu_src_dec = 1'b0; end
      default:         begin alu_op_dec = '0;              alu_src_dec = 1'b0; end
    endcase
  end

  // Next-state, opcode capture, wait counter and per-state control outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = '0;
    ALUOp_o    = '0;
    ALUSrc_o   = 1'b0;
    RegWrite_o = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    MemToReg_o = 1'b0;
    Branch_o   = 1'b0;
    PCWrite_o  = 1'b0;
    IRWrite_o  = 1'b0;
    IorD_o     = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        MemRead_o = 1'b1;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = ST_DECODE;
        end else if (cnt_hit) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        op_d = Op_i;
        if (No_op_i) begin
          op_d    = '0;
          state_d = end_state;
        end else if (op_in_legal) begin
          state_d = ST_EXEC;
        end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d = ST_ERR;
`else
          op_d    = '0;
          state_d = end_state;
`endif
        end
      end
      ST_EXEC: begin
        ALUOp_o  = alu_op_dec;
        ALUSrc_o = alu_src_dec;
        case (op_q)
          OPC_R, OPC_I:       state_d = ST_WB;
          OPC_LOAD, OPC_STORE: state_d = ST_MEM;
          OPC_BRANCH: begin
            Branch_o  = 1'b1;
            PCWrite_o = branch_taken_i;
            state_d   = end_state;
          end
          default:            state_d = end_state;
        endcase
      end
      ST_MEM: begin
        ALUOp_o    = alu_op_dec;
        ALUSrc_o   = alu_src_dec;
        IorD_o     = 1'b1;
        MemRead_o  = is_load_q;
        MemWrite_o = is_store_q;
        if (mem_ready_i) begin
          state_d = is_load_q ? ST_WB : end_state;
        end else if (cnt_hit) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        ALUOp_o    = alu_op_dec;
        ALUSrc_o   = alu_src_dec;
        RegWrite_o = 1'b1;
        MemToReg_o = is_load_q;
        state_d    = end_state;
      end
      ST_ERR: begin
        err_o = 1'b1;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

endmodule
